// File: rtl/countdown_timer.sv
// Loadable HH:MM:SS countdown timer driven by a 1 Hz strobe.
// Borrows cascade seconds -> minutes -> hours within a single edge; expiry pulses o_done and latches o_alarm.
module countdown_timer #(
    parameter int HOUR_WIDTH = 5,
    parameter int MIN_WIDTH  = 6,
    parameter int SEC_WIDTH  = 6,
    parameter int MAX_HOURS  = 23
) (
    input  logic                  i_sysclk,
    input  logic                  i_reset,
    input  logic                  i_tick,
    input  logic                  i_load,
    input  logic [HOUR_WIDTH-1:0] i_hours,
    input  logic [MIN_WIDTH-1:0]  i_minutes,
    input  logic [SEC_WIDTH-1:0]  i_seconds,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_clear,
    output logic [HOUR_WIDTH-1:0] o_hours,
    output logic [MIN_WIDTH-1:0]  o_minutes,
    output logic [SEC_WIDTH-1:0]  o_seconds,
    output logic [1:0]            o_state,
    output logic                  o_running,
    output logic                  o_done,
    output logic                  o_alarm
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_EXPIRED = 2'b11
    } state_t;

    localparam logic [HOUR_WIDTH-1:0] HOUR_LIMIT = HOUR_WIDTH'(MAX_HOURS);
    localparam logic [MIN_WIDTH-1:0]  MIN_LIMIT  = MIN_WIDTH'(32'd59);
    localparam logic [SEC_WIDTH-1:0]  SEC_LIMIT  = SEC_WIDTH'(32'd59);
    localparam logic [HOUR_WIDTH-1:0] HOUR_ZERO  = {HOUR_WIDTH{1'b0}};
    localparam logic [MIN_WIDTH-1:0]  MIN_ZERO   = {MIN_WIDTH{1'b0}};
    localparam logic [SEC_WIDTH-1:0]  SEC_ZERO   = {SEC_WIDTH{1'b0}};
    localparam logic [HOUR_WIDTH-1:0] HOUR_ONE   = HOUR_WIDTH'(32'd1);
    localparam logic [MIN_WIDTH-1:0]  MIN_ONE    = MIN_WIDTH'(32'd1);
    localparam logic [SEC_WIDTH-1:0]  SEC_ONE    = SEC_WIDTH'(32'd1);

    function automatic logic [HOUR_WIDTH-1:0] clamp_hours(input logic [HOUR_WIDTH-1:0] v);
        return (v > HOUR_LIMIT) ? HOUR_LIMIT : v;
    endfunction

    function automatic logic [MIN_WIDTH-1:0] clamp_minutes(input logic [MIN_WIDTH-1:0] v);
        return (v > MIN_LIMIT) ? MIN_LIMIT : v;
    endfunction

    function automatic logic [SEC_WIDTH-1:0] clamp_seconds(input logic [SEC_WIDTH-1:0] v);
        return (v > SEC_LIMIT) ? SEC_LIMIT : v;
    endfunction

    state_t                  state_r, state_s;
    logic [HOUR_WIDTH-1:0]   hours_r, hours_s;
    logic [MIN_WIDTH-1:0]    minutes_r, minutes_s;
    logic [SEC_WIDTH-1:0]    seconds_r, seconds_s;
    logic                    done_r, done_s;
    logic                    running_r;
    logic                    alarm_r;
    logic                    count_zero_s;
    logic                    count_one_s;

    // Zero / last-second detection on the current count.
    always_comb begin
        count_zero_s = (hours_r == HOUR_ZERO) && (minutes_r == MIN_ZERO) && (seconds_r == SEC_ZERO);
        count_one_s  = (hours_r == HOUR_ZERO) && (minutes_r == MIN_ZERO) && (seconds_r == SEC_ONE);
    end

    // Next-state and next-count logic, controls in priority order clear > load > stop > start > tick.
    always_comb begin
        state_s   = state_r;
        hours_s   = hours_r;
        minutes_s = minutes_r;
        seconds_s = seconds_r;
        done_s    = 1'b0;
        if (i_clear) begin
            hours_s   = HOUR_ZERO;
            minutes_s = MIN_ZERO;
            seconds_s = SEC_ZERO;
            state_s   = ST_IDLE;
        end else if (i_load) begin
            hours_s   = clamp_hours(i_hours);
            minutes_s = clamp_minutes(i_minutes);
            seconds_s = clamp_seconds(i_seconds);
            case (state_r)
                ST_RUN, ST_PAUSED:   state_s = ST_PAUSED;
                ST_IDLE, ST_EXPIRED: state_s = ST_IDLE;
                default:             state_s = ST_IDLE;
            endcase
        end else if (i_stop && (state_r == ST_RUN)) begin
            state_s = ST_PAUSED;
        end else if (i_start) begin
            case (state_r)
                ST_IDLE, ST_PAUSED: begin
                    if (!count_zero_s) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_EXPIRED: state_s = ST_IDLE;
                ST_RUN:     state_s = ST_RUN;
                default:    state_s = ST_IDLE;
            endcase
        end else if (i_tick && (state_r == ST_RUN)) begin
            // The final second lands on zero and expires in the same edge.
            if (count_one_s) begin
                seconds_s = SEC_ZERO;
                state_s   = ST_EXPIRED;
                done_s    = 1'b1;
            end else if (seconds_r != SEC_ZERO) begin
                seconds_s = seconds_r - SEC_ONE;
            end else if (minutes_r != MIN_ZERO) begin
                seconds_s = SEC_LIMIT;
                minutes_s = minutes_r - MIN_ONE;
            end else if (hours_r != HOUR_ZERO) begin
                seconds_s = SEC_LIMIT;
                minutes_s = MIN_LIMIT;
                hours_s   = hours_r - HOUR_ONE;
            end else begin
                state_s = ST_EXPIRED;
            end
        end else begin
            case (state_r)
                ST_IDLE, ST_RUN, ST_PAUSED, ST_EXPIRED: state_s = state_r;
                default:                                state_s = ST_IDLE;
            endcase
        end
    end

    // State, count and registered status flags.
    always_ff @(posedge i_sysclk) begin
        if (i_reset) begin
            state_r   <= ST_IDLE;
            hours_r   <= HOUR_ZERO;
            minutes_r <= MIN_ZERO;
            seconds_r <= SEC_ZERO;
            done_r    <= 1'b0;
            running_r <= 1'b0;
            alarm_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            hours_r   <= hours_s;
            minutes_r <= minutes_s;
            seconds_r <= seconds_s;
            done_r    <= done_s;
            running_r <= (state_s == ST_RUN);
            alarm_r   <= (state_s == ST_EXPIRED);
        end
    end

    assign o_hours   = hours_r;
    assign o_minutes = minutes_r;
    assign o_seconds = seconds_r;
    assign o_state   = state_r;
    assign o_running = running_r;
    assign o_done    = done_r;
    assign o_alarm   = alarm_r;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: a total-seconds reference model queues the expected
// outputs for each edge and a negedge monitor compares them with the DUT.
module tb_countdown_timer;

    localparam int IDLE = 0, RUN = 1, PAUSED = 2, EXPIRED = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0, tk = 1'b0, ld = 1'b0, st = 1'b0, sp = 1'b0, clr = 1'b0;
    logic [4:0] lh = 5'd0;
    logic [5:0] lm = 6'd0, ls = 6'd0;
    logic [4:0] o_h;
    logic [5:0] o_m, o_s;
    logic [1:0] o_st;
    logic       o_run, o_done, o_alarm;

    countdown_timer dut (
        .i_sysclk (clk),   .i_reset (rst),  .i_tick (tk),    .i_load (ld),
        .i_hours  (lh),    .i_minutes (lm), .i_seconds (ls),
        .i_start  (st),    .i_stop (sp),    .i_clear (clr),
        .o_hours  (o_h),   .o_minutes (o_m), .o_seconds (o_s),
        .o_state  (o_st),  .o_running (o_run), .o_done (o_done), .o_alarm (o_alarm)
    );

    always #5 clk = ~clk;

    typedef struct {
        int step;
        int h, m, s, state;
        bit run, done, alarm;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   tests = 0, fails = 0, step = 0;
    int   m_total = 0, m_state = IDLE;
    bit   m_done = 1'b0;

    function automatic int clampi(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    // Reference model: count kept as total seconds, applied with the inputs seen at this edge.
    task automatic model_edge();
        exp_t x;
        m_done = 1'b0;
        if (rst) begin
            m_total = 0;
            m_state = IDLE;
        end else if (clr) begin
            m_total = 0;
            m_state = IDLE;
        end else if (ld) begin
            m_total = clampi(int'(lh), 23) * 3600 + clampi(int'(lm), 59) * 60 + clampi(int'(ls), 59);
            m_state = (m_state == RUN || m_state == PAUSED) ? PAUSED : IDLE;
        end else if (sp && m_state == RUN) begin
            m_state = PAUSED;
        end else if (st) begin
            if ((m_state == IDLE || m_state == PAUSED) && m_total > 0) m_state = RUN;
            else if (m_state == EXPIRED) m_state = IDLE;
        end else if (tk && m_state == RUN && m_total > 0) begin
            m_total = m_total - 1;
            if (m_total == 0) begin
                m_state = EXPIRED;
                m_done  = 1'b1;
            end
        end
        x.step  = step;
        x.h     = m_total / 3600;
        x.m     = (m_total / 60) % 60;
        x.s     = m_total % 60;
        x.state = m_state;
        x.run   = (m_state == RUN);
        x.alarm = (m_state == EXPIRED);
        x.done  = m_done;
        q.push_back(x);
    endtask

    // Apply the currently driven controls for one edge, queue the expectation, then release them.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        step = step + 1;
        #1;
        rst = 1'b0; tk = 1'b0; ld = 1'b0; st = 1'b0; sp = 1'b0; clr = 1'b0;
    endtask

    task automatic do_load(input int h, input int m, input int s);
        ld = 1'b1; lh = 5'(h); lm = 6'(m); ls = 6'(s);
        cyc();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Monitor: outputs are presented every cycle; compare against the oldest expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            tests = tests + 1;
            if (int'(o_h) != e.h || int'(o_m) != e.m || int'(o_s) != e.s || int'(o_st) != e.state ||
                o_run != e.run || o_done != e.done || o_alarm != e.alarm) begin
                fails = fails + 1;
                $display("FAIL step %0d outputs: got %0d:%0d:%0d st=%0d run=%0b done=%0b alarm=%0b, want %0d:%0d:%0d st=%0d run=%0b done=%0b alarm=%0b",
                         e.step, o_h, o_m, o_s, o_st, o_run, o_done, o_alarm,
                         e.h, e.m, e.s, e.state, e.run, e.done, e.alarm);
            end
        end
    end

    initial begin
        int r, wait_cnt;
        // Reset and hold
        #2;
        rst = 1'b1; cyc();
        idle(10);
        // Three-second countdown to expiry, alarm held, then acknowledged
        do_load(0, 0, 3);
        st = 1'b1; cyc();
        for (int i = 0; i < 3; i++) begin tk = 1'b1; cyc(); end
        idle(3);
        tk = 1'b1; cyc();
        st = 1'b1; cyc();
        idle(1);
        // Borrow cascades
        do_load(2, 0, 0);
        st = 1'b1; cyc();
        tk = 1'b1; cyc();
        do_load(0, 1, 0);
        st = 1'b1; cyc();
        tk = 1'b1; cyc();
        // Clamping and start on zero
        do_load(30, 63, 63);
        idle(1);
        do_load(0, 0, 0);
        st = 1'b1; cyc();
        idle(2);
        // Stop/tick collision, ticks while paused, resume, start+stop collision
        do_load(0, 0, 10);
        st = 1'b1; cyc();
        sp = 1'b1; tk = 1'b1; cyc();
        for (int i = 0; i < 5; i++) begin tk = 1'b1; cyc(); end
        st = 1'b1; cyc();
        tk = 1'b1; cyc();
        st = 1'b1; sp = 1'b1; cyc();
        // Clear with tick at the last second, load during RUN, reset mid-count
        do_load(0, 0, 1);
        st = 1'b1; cyc();
        clr = 1'b1; tk = 1'b1; cyc();
        do_load(0, 5, 0);
        st = 1'b1; cyc();
        tk = 1'b1; cyc();
        do_load(0, 5, 0);
        st = 1'b1; cyc();
        tk = 1'b1; cyc();
        rst = 1'b1; cyc();
        idle(2);
        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            r  = $urandom_range(0, 199);
            tk = ($urandom_range(0, 1) == 1);
            if (r < 1) begin
                rst = 1'b1;
            end else if (r < 4) begin
                clr = 1'b1;
            end else if (r < 14) begin
                ld = 1'b1;
                if ($urandom_range(0, 1) == 1) begin
                    lh = 5'd0; lm = 6'($urandom_range(0, 1)); ls = 6'($urandom_range(0, 20));
                end else begin
                    lh = 5'($urandom_range(0, 31)); lm = 6'($urandom_range(0, 63)); ls = 6'($urandom_range(0, 63));
                end
            end else if (r < 20) begin
                sp = 1'b1;
            end else if (r < 40) begin
                st = 1'b1;
            end
            cyc();
        end
        idle(2);
        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt = wait_cnt + 1;
        end
        #1;
        tests = tests + 1;
        if (q.size() != 0) begin
            fails = fails + 1;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
